// File: rtl/video_pkg.sv
// video_pkg: tile-map geometry, blitter op encoding and blitter state encoding,
// shared between the VRAM blitter and the video unit.
// Optional feature macro: BLIT_COPY_EN (adds the copy states to the state enum).
package video_pkg;

  localparam int TILES_H   = 28;
  localparam int TILES_V   = 18;
  localparam int BPP       = 2;
  localparam int VRAM_SIZE = (TILES_H * TILES_V * BPP) / 8;

  typedef enum logic {
    OP_FILL = 1'b0,
    OP_COPY = 1'b1
  } blit_op_e;

`ifdef BLIT_COPY_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_COPY_RD  = 3'd2,
    ST_COPY_LAT = 3'd3,
    ST_COPY_WR  = 3'd4,
    ST_DONE     = 3'd5
  } blit_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } blit_state_e;
`endif

endpackage

// File: rtl/vram_blitter.sv
// vram_blitter: fill / copy engine sharing VRAM port 1 with the CPU.
// The CPU always wins the port; the blitter simply freezes while cpu_en is high.
// Optional feature macro: BLIT_COPY_EN enables the copy operation and its
// read/latency/write states plus the data latch. Without it a copy command
// completes immediately without touching VRAM.
module vram_blitter #(
  parameter int VRAM_SIZE = video_pkg::VRAM_SIZE,
  parameter int ADDR_W    = $clog2(VRAM_SIZE)
) (
  input  logic              wclk,
  input  logic              rst_n,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [7:0]        cmd_fill,
  input  logic              cmd_abort,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_wdata,
  output logic              vram_wenable,
  input  logic [7:0]        vram_rdata,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0] LEN_ONE = (ADDR_W+1)'(1);

  video_pkg::blit_state_e state_q, state_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic [7:0]        fill_q, fill_d;

`ifdef BLIT_COPY_EN
  logic [ADDR_W-1:0] src_q, src_d;
  logic [7:0]        latch_q, latch_d;
`else
  logic src_unused;
  assign src_unused = ^cmd_src;
`endif

  logic              stall;
  logic              blit_we;
  logic [ADDR_W-1:0] blit_addr;
  logic [7:0]        blit_wdata;

  assign stall = cpu_en;

  // Addresses walk through VRAM and wrap from the last byte back to byte 0.
  function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] a);
    if (a >= ADDR_W'(VRAM_SIZE - 1)) begin
      return '0;
    end
    return a + ADDR_W'(1);
  endfunction

  // State, counters and latch; reset drops any command in flight.
  always_ff @(posedge wclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= video_pkg::ST_IDLE;
      dst_q   <= '0;
      rem_q   <= '0;
      fill_q  <= '0;
`ifdef BLIT_COPY_EN
      src_q   <= '0;
      latch_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
`ifdef BLIT_COPY_EN
      src_q   <= src_d;
      latch_q <= latch_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, advance only when the CPU leaves the port free.
  always_comb begin
    state_d = state_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
`ifdef BLIT_COPY_EN
    src_d   = src_q;
    latch_d = latch_q;
`endif
    unique case (state_q)
      video_pkg::ST_IDLE: begin
        if (cmd_valid) begin
          dst_d  = cmd_dst;
          rem_d  = cmd_len;
          fill_d = cmd_fill;
`ifdef BLIT_COPY_EN
          src_d  = cmd_src;
`endif
          if (cmd_len == '0) begin
            state_d = video_pkg::ST_DONE;
          end else if (cmd_op == video_pkg::OP_FILL) begin
            state_d = video_pkg::ST_FILL;
          end else begin
`ifdef BLIT_COPY_EN
            state_d = video_pkg::ST_COPY_RD;
`else
            state_d = video_pkg::ST_DONE;
`endif
          end
        end
      end
      video_pkg::ST_FILL: begin
        if (cmd_abort) begin
          state_d = video_pkg::ST_DONE;
        end else if (!stall) begin
          dst_d = wrap_inc(dst_q);
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = video_pkg::ST_DONE;
          end
        end
      end
`ifdef BLIT_COPY_EN
      video_pkg::ST_COPY_RD: begin
        if (cmd_abort) begin
          state_d = video_pkg::ST_DONE;
        end else if (!stall) begin
          src_d   = wrap_inc(src_q);
          state_d = video_pkg::ST_COPY_LAT;
        end
      end
      video_pkg::ST_COPY_LAT: begin
        if (cmd_abort) begin
          state_d = video_pkg::ST_DONE;
        end else begin
          latch_d = vram_rdata;
          state_d = video_pkg::ST_COPY_WR;
        end
      end
      video_pkg::ST_COPY_WR: begin
        if (cmd_abort) begin
          state_d = video_pkg::ST_DONE;
        end else if (!stall) begin
          dst_d = wrap_inc(dst_q);
          rem_d = rem_q - LEN_ONE;
          if (rem_q == LEN_ONE) begin
            state_d = video_pkg::ST_DONE;
          end else begin
            state_d = video_pkg::ST_COPY_RD;
          end
        end
      end
`endif
      video_pkg::ST_DONE: begin
        state_d = video_pkg::ST_IDLE;
      end
      default: begin
        state_d = video_pkg::ST_IDLE;
      end
    endcase
  end

  // Blitter's own view of the port: which address it presents and whether it writes.
  always_comb begin
    blit_we    = 1'b0;
    blit_addr  = '0;
    blit_wdata = fill_q;
    unique case (state_q)
      video_pkg::ST_IDLE: begin
        blit_addr = '0;
      end
      video_pkg::ST_FILL: begin
        blit_addr = dst_q;
        blit_we   = 1'b1;
      end
`ifdef BLIT_COPY_EN
      video_pkg::ST_COPY_RD: begin
        blit_addr = src_q;
      end
      video_pkg::ST_COPY_LAT: begin
        blit_addr = dst_q;
      end
      video_pkg::ST_COPY_WR: begin
        blit_addr  = dst_q;
        blit_we    = 1'b1;
        blit_wdata = latch_q;
      end
`endif
      video_pkg::ST_DONE: begin
        blit_addr = dst_q;
      end
      default: begin
        blit_addr = '0;
      end
    endcase
  end

  assign vram_addr    = cpu_en ? cpu_addr  : blit_addr;
  assign vram_wdata   = cpu_en ? cpu_wdata : blit_wdata;
  assign vram_wenable = cpu_en ? cpu_we    : blit_we;
  assign cpu_rdata    = vram_rdata;

  assign cmd_ready = (state_q == video_pkg::ST_IDLE);
  assign busy      = (state_q != video_pkg::ST_IDLE);
  assign done      = (state_q == video_pkg::ST_DONE);

endmodule

// File: doc/vram_blitter.md
VRAM_BLITTER -- requirements
Module: vram_blitter

Interface
- REQ-001: Parameter VRAM_SIZE, default 126, SHALL be the VRAM depth in bytes (28x18 tiles, 2 bpp).
- REQ-002: Parameter ADDR_W, default $clog2(VRAM_SIZE), SHALL be the VRAM byte-address width.
- REQ-003: wclk  in  1  SHALL be the clock; all state changes on its rising edge.
- REQ-004: rst_n  in  1  SHALL be the reset: asynchronous, active-low.
- REQ-005: cpu_en  in  1  SHALL flag a CPU VRAM access this cycle.
- REQ-006: cpu_we  in  1  SHALL mark the CPU access as a write.
- REQ-007: cpu_addr  in  ADDR_W, cpu_wdata  in  8  SHALL carry the CPU access.
- REQ-008: cpu_rdata  out  8  SHALL equal vram_rdata.
- REQ-009: cmd_valid  in  1, cmd_ready  out  1  SHALL form the command handshake.
- REQ-010: cmd_op  in  1  SHALL select the operation: 0 fill, 1 copy.
- REQ-011: cmd_dst, cmd_src  in  ADDR_W, cmd_len  in  ADDR_W+1, cmd_fill  in  8  SHALL carry the command fields.
- REQ-012: cmd_abort  in  1  SHALL request termination of the running command.
- REQ-013: vram_addr  out  ADDR_W, vram_wdata  out  8, vram_wenable  out  1  SHALL drive VRAM port 1.
- REQ-014: vram_rdata  in  8  SHALL be VRAM read data, valid one cycle after its address.
- REQ-015: busy  out  1  SHALL be high whenever state is not IDLE.
- REQ-016: done  out  1  SHALL pulse for one cycle on completion or abort.

Function
- REQ-017: The CPU SHALL have absolute priority: while cpu_en=1, vram_addr, vram_wdata and vram_wenable come from the CPU inputs (vram_wenable=cpu_we) in the same cycle, and the blitter stalls in place.
- REQ-018: cmd_ready SHALL be 1 only in IDLE; a command is accepted on cmd_valid&cmd_ready, with fields latched into internal registers.
- REQ-019: States SHALL be IDLE, FILL, COPY_RD, COPY_LAT, COPY_WR, DONE.
- REQ-020: When a command is accepted with cmd_len=0, the next state SHALL be DONE and no VRAM write occurs.
- REQ-021: FILL, when not stalled, SHALL write cmd_fill to dst, then increment dst, decrement remaining, and go to DONE when remaining reaches 0; throughput is 1 byte/cycle.
- REQ-022: Copy SHALL proceed COPY_RD (present src) -> COPY_LAT (latch vram_rdata, no port use, never stalls) -> COPY_WR (write latch to dst), at 3 cycles/byte unstalled.
- REQ-023: A stall in COPY_RD or COPY_WR SHALL hold the state; latched data is preserved.
- REQ-024: dst and src SHALL increment modulo VRAM_SIZE (VRAM_SIZE-1 -> 0).
- REQ-025: cmd_len > VRAM_SIZE SHALL be processed as given, with addresses wrapping.
- REQ-026: DONE SHALL assert done for one cycle and return to IDLE.
- REQ-027: cmd_abort in any busy state other than DONE SHALL go to DONE next cycle with no further writes; an abort in the same cycle as a write still lets that write occur.
- REQ-028: When the blitter is not writing, vram_wenable SHALL be 0; vram_addr SHALL equal the blitter address (dst, or src in COPY_RD), or 0 in IDLE.

Reset
- REQ-029: On rst_n=0, the state SHALL go to IDLE; busy=0, done=0, internal counters and latch=0, cmd_ready=1.
- REQ-030: A reset during a command SHALL drop it with no further blitter writes; CPU pass-through stays combinational.

Configuration
- REQ-031: With BLIT_COPY_EN defined, copy SHALL be supported as above.
- REQ-032: Without BLIT_COPY_EN, the COPY_* states and the latch SHALL be absent, and an accepted cmd_op=1 goes directly to DONE without writes.

Structure
- REQ-033: Package video_pkg SHALL hold the VRAM_SIZE/TILES_H/TILES_V constants, the op encoding and the state enum, shared with the video unit.
- REQ-034: The block SHALL be a single module, with no sub-module.

Verification
- REQ-035: Fill dst=10, len=4, fill=0xA5 -> writes at addr 10..13 in 4 consecutive cycles, then done pulse; cmd_ready returns.
- REQ-036: Fill with cpu_en high for 2 cycles mid-run -> CPU accesses pass through unchanged, fill finishes 2 cycles late, all 4 bytes written.
- REQ-037: Copy src=0, dst=124, len=4 (VRAM preset 1,2,3,4) -> bytes 124,125,0,1 = 1,2,3,4; done after 12 cycles unstalled.
- REQ-038: cmd_len=0 -> no writes, done exactly 1 cycle after acceptance.
- REQ-039: cmd_abort on the 3rd byte of a len=8 fill -> bytes 0-2 written, no more writes, single done pulse; rst_n low mid-copy -> busy=0 immediately, no writes.
